// File: rtl/pixel_sample_extractor.sv
// pixel_sample_extractor
//   Picks one pixel per video line at a fixed column, turns it into a 1-bit
//   level with hysteresis thresholds and filters that level across lines.
//   Feeds sample_data / sample_valid to a frequency_analyzer instance.
//
// Ports
//   clock          single clock
//   reset          synchronous, active-high; same effect as enable=0
//   enable         run control; low clears the block to IDLE
//   data           pixel value
//   data_valid     data carries a pixel this cycle
//   line_start     with data_valid, marks column 0 of a new line
//   sample_data    filtered pixel level
//   sample_valid   one-cycle pulse per captured line
//   pixel_value    last captured raw pixel
//   missed_pulse   one-cycle pulse when a line ends before PIXEL_INDEX
//   missed_count   saturating count of missed lines
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | cleared; moves to WAIT_LINE one cycle after enable
// WAIT_LINE | discarding beats until the first line_start beat
// COUNT     | inside a line, counting columns toward PIXEL_INDEX
// DONE      | pixel of this line captured; waiting for next line_start
module pixel_sample_extractor #(
  parameter int DATA_WIDTH     = 8,
  parameter int INDEX_WIDTH    = 10,
  parameter int PIXEL_INDEX    = 63,
  parameter int THRESHOLD_HIGH = 160,
  parameter int THRESHOLD_LOW  = 96,
  parameter int FILTER_LENGTH  = 2,
  parameter int MISSED_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic                    data_valid,
  input  logic                    line_start,
  output logic                    sample_data,
  output logic                    sample_valid,
  output logic [DATA_WIDTH-1:0]   pixel_value,
  output logic                    missed_pulse,
  output logic [MISSED_WIDTH-1:0] missed_count
);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, COUNT, DONE} state_t;

  localparam logic [INDEX_WIDTH-1:0]  PIX_IDX     = INDEX_WIDTH'(PIXEL_INDEX);
  localparam logic [INDEX_WIDTH-1:0]  COLUMN_MAX  = '1;
  localparam logic [MISSED_WIDTH-1:0] MISSED_MAX  = '1;
  localparam logic [DATA_WIDTH-1:0]   TH_HIGH     = DATA_WIDTH'(THRESHOLD_HIGH);
  localparam logic [DATA_WIDTH-1:0]   TH_LOW      = DATA_WIDTH'(THRESHOLD_LOW);
  localparam logic [3:0]              FILTER_LEN  = 4'(FILTER_LENGTH);

  state_t                 state;
  logic [INDEX_WIDTH-1:0] column;
  logic [3:0]             filter_count;
  logic                   capture_pending;
  logic                   candidate;
  logic                   line_beat;
  logic                   pixel_beat;

  assign line_beat  = data_valid & line_start;
  assign pixel_beat = data_valid & ~line_start;

  // Candidate is derived from the registered capture one cycle after the
  // capture beat, so back-to-back captures always see the updated level.
  always_comb begin
    candidate = sample_data;
    if (pixel_value >= TH_HIGH)
      candidate = 1'b1;
    else if (pixel_value <= TH_LOW)
      candidate = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      state           <= IDLE;
      column          <= '0;
      filter_count    <= '0;
      capture_pending <= 1'b0;
      sample_data     <= 1'b0;
      sample_valid    <= 1'b0;
      pixel_value     <= '0;
      missed_pulse    <= 1'b0;
      missed_count    <= '0;
    end else begin
      sample_valid    <= capture_pending;
      missed_pulse    <= 1'b0;
      capture_pending <= 1'b0;

      if (capture_pending) begin
        if (candidate == sample_data) begin
          filter_count <= '0;
        end else if (filter_count + 4'd1 >= FILTER_LEN) begin
          sample_data  <= ~sample_data;
          filter_count <= '0;
        end else begin
          filter_count <= filter_count + 4'd1;
        end
      end

      case (state)
        IDLE: state <= WAIT_LINE;
        WAIT_LINE, COUNT, DONE: begin
          if (line_beat) begin
            // A new line while still counting means the previous line was
            // too short to reach the capture column.
            if (state == COUNT) begin
              missed_pulse <= 1'b1;
              if (missed_count != MISSED_MAX)
                missed_count <= missed_count + 1'b1;
            end
            column <= INDEX_WIDTH'(1);
            if (PIXEL_INDEX == 0) begin
              pixel_value     <= data;
              capture_pending <= 1'b1;
              state           <= DONE;
            end else begin
              state <= COUNT;
            end
          end else if (pixel_beat && state == COUNT) begin
            if (column == PIX_IDX) begin
              pixel_value     <= data;
              capture_pending <= 1'b1;
              state           <= DONE;
            end
            if (column != COLUMN_MAX)
              column <= column + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sample_extractor.sv
module tb_pixel_sample_extractor;

  logic       clock = 1'b0;
  logic       reset, enable, data_valid, line_start;
  logic [7:0] data;

  logic       sd [4];
  logic       sv [4];
  logic       mp [4];
  logic [7:0] pv [4];
  logic [15:0] mc [4];
  logic [3:0] mc_d;

  assign mc[3] = {12'd0, mc_d};

  always #5 clock = ~clock;

  localparam int IDX [4] = '{63, 0, 1023, 5};
  localparam int FLT [4] = '{2, 1, 3, 2};
  localparam int MW  [4] = '{16, 16, 16, 4};

  int errors = 0;
  int checks = 0;

  // Behavioural model: per-line column position plus a two-step pipeline.
  int m_col  [4];
  bit m_got  [4];
  bit m_run  [4];
  bit m_sd   [4];
  bit m_sv   [4];
  bit m_mp   [4];
  bit m_pend [4];
  int m_fc   [4];
  int m_pv   [4];
  int m_mc   [4];

  pixel_sample_extractor #(.PIXEL_INDEX(63)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .data(data),
    .data_valid(data_valid), .line_start(line_start),
    .sample_data(sd[0]), .sample_valid(sv[0]), .pixel_value(pv[0]),
    .missed_pulse(mp[0]), .missed_count(mc[0]));

  pixel_sample_extractor #(.PIXEL_INDEX(0), .FILTER_LENGTH(1)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .data(data),
    .data_valid(data_valid), .line_start(line_start),
    .sample_data(sd[1]), .sample_valid(sv[1]), .pixel_value(pv[1]),
    .missed_pulse(mp[1]), .missed_count(mc[1]));

  pixel_sample_extractor #(.PIXEL_INDEX(1023), .FILTER_LENGTH(3)) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .data(data),
    .data_valid(data_valid), .line_start(line_start),
    .sample_data(sd[2]), .sample_valid(sv[2]), .pixel_value(pv[2]),
    .missed_pulse(mp[2]), .missed_count(mc[2]));

  pixel_sample_extractor #(.PIXEL_INDEX(5), .MISSED_WIDTH(4)) dut_d (
    .clock(clock), .reset(reset), .enable(enable), .data(data),
    .data_valid(data_valid), .line_start(line_start),
    .sample_data(sd[3]), .sample_valid(sv[3]), .pixel_value(pv[3]),
    .missed_pulse(mp[3]), .missed_count(mc_d));

  // Advance the model by one clock using the inputs as they stand, then
  // let the DUTs take the same edge and settle.
  task automatic tick();
    for (int i = 0; i < 4; i++) begin
      bit cand, in_line, ncap, nmp;
      if (reset || !enable) begin
        m_run[i] = 0; m_col[i] = -1; m_got[i] = 0; m_sd[i] = 0; m_fc[i] = 0;
        m_pv[i] = 0; m_sv[i] = 0; m_mp[i] = 0; m_mc[i] = 0; m_pend[i] = 0;
      end else begin
        m_sv[i] = m_pend[i];
        if (m_pend[i]) begin
          if (m_pv[i] >= 160) cand = 1;
          else if (m_pv[i] <= 96) cand = 0;
          else cand = m_sd[i];
          if (cand == m_sd[i]) m_fc[i] = 0;
          else begin
            m_fc[i]++;
            if (m_fc[i] >= FLT[i]) begin
              m_sd[i] = !m_sd[i];
              m_fc[i] = 0;
            end
          end
        end
        ncap = 0;
        nmp  = 0;
        if (!m_run[i]) m_run[i] = 1;
        else if (data_valid) begin
          in_line = (m_col[i] >= 0) && !m_got[i];
          if (line_start) begin
            if (in_line) begin
              nmp = 1;
              if (m_mc[i] < (1 << MW[i]) - 1) m_mc[i]++;
            end
            m_col[i] = 0;
            m_got[i] = 0;
          end else if (in_line) begin
            m_col[i]++;
          end
          if (m_col[i] >= 0 && !m_got[i] && m_col[i] == IDX[i]) begin
            ncap = 1;
            m_pv[i] = int'(data);
            m_got[i] = 1;
          end
        end
        m_mp[i]   = nmp;
        m_pend[i] = ncap;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input bit v, input bit ls, input logic [7:0] d);
    data_valid = v;
    line_start = ls;
    data       = d;
    tick();
  endtask

  task automatic restart();
    reset = 1; enable = 1;
    beat(0, 0, 8'd0);
    reset = 0;
    beat(0, 0, 8'd0);
  endtask

  // 100-pixel line on dut_a with val at column 63 and 0 elsewhere.
  task automatic basic_line(input int val, input bit want_sd, input bit want_miss);
    for (int col = 0; col < 100; col++) begin
      beat(1, col == 0, (col == 63) ? 8'(val) : 8'd0);
      if (col == 0) begin
        checks++;
        if (mp[0] !== want_miss) begin
          errors++;
          $display("FAIL line_miss_pulse got %0b want %0b", mp[0], want_miss);
        end
      end
      if (col == 1) begin
        checks++;
        if (mp[0] !== 1'b0) begin
          errors++;
          $display("FAIL line_miss_width got %0b want 0", mp[0]);
        end
      end
      if (col == 63) begin
        checks++;
        if (pv[0] !== 8'(val) || sv[0] !== 1'b0) begin
          errors++;
          $display("FAIL capture_plus1 pv=%0d sv=%0b want pv=%0d sv=0", pv[0], sv[0], val);
        end
      end
      if (col == 64) begin
        checks++;
        if (sv[0] !== 1'b1 || sd[0] !== want_sd) begin
          errors++;
          $display("FAIL capture_plus2 sv=%0b sd=%0b want sv=1 sd=%0b", sv[0], sd[0], want_sd);
        end
      end
      if (col == 65) begin
        checks++;
        if (sv[0] !== 1'b0) begin
          errors++;
          $display("FAIL valid_width sv=%0b want 0", sv[0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; data_valid = 1; line_start = 1; data = 8'hFF;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sd[i] !== 1'b0 || sv[i] !== 1'b0 || mp[i] !== 1'b0 || pv[i] !== 8'd0 || mc[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_dut%0d sd=%0b sv=%0b mp=%0b pv=%0d mc=%0d want all 0",
                 i, sd[i], sv[i], mp[i], pv[i], mc[i]);
      end
    end
  endtask

  task automatic test_basic_hysteresis();
    restart();
    basic_line(200, 0, 0);
    basic_line(200, 1, 0);
    basic_line(120, 1, 0);
    basic_line(120, 1, 0);
    basic_line(120, 1, 0);
    basic_line(90, 1, 0);
    basic_line(90, 0, 0);
  endtask

  task automatic test_short_line();
    int sv_seen = 0;
    for (int col = 0; col < 40; col++) begin
      beat(1, col == 0, 8'd200);
      sv_seen += int'(sv[0]);
    end
    checks++;
    if (sv_seen != 0) begin
      errors++;
      $display("FAIL short_no_valid got %0d pulses want 0", sv_seen);
    end
    basic_line(200, 0, 1);
    checks++;
    if (mc[0] !== 16'd1) begin
      errors++;
      $display("FAIL short_missed_count got %0d want 1", mc[0]);
    end
  endtask

  task automatic test_gaps_boundary();
    bit exp_sd = 0;
    int sv_seen;
    logic [7:0] val;
    restart();
    for (int ln = 0; ln < 10; ln++) begin
      val = 8'($urandom_range(0, 255));
      beat(1, 1, val);
      checks++;
      if (pv[1] !== val) begin
        errors++;
        $display("FAIL gap_idx0_capture got %0d want %0d", pv[1], val);
      end
      beat(0, 1, 8'($urandom_range(0, 255)));
      if (val >= 160) exp_sd = 1;
      else if (val <= 96) exp_sd = 0;
      checks++;
      if (sv[1] !== 1'b1 || sd[1] !== exp_sd) begin
        errors++;
        $display("FAIL gap_idx0_level sv=%0b sd=%0b want sv=1 sd=%0b", sv[1], sd[1], exp_sd);
      end
      sv_seen = 0;
      for (int k = 0; k < 4; k++) begin
        beat(1, 0, 8'($urandom_range(0, 255)));
        sv_seen += int'(sv[1]);
        beat(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        sv_seen += int'(sv[1]);
      end
      checks++;
      if (sv_seen != 0) begin
        errors++;
        $display("FAIL gap_idx0_single got %0d extra pulses want 0", sv_seen);
      end
    end

    restart();
    for (int col = 0; col < 1024; col++)
      beat(1, col == 0, (col == 1023) ? 8'd250 : 8'd7);
    checks++;
    if (pv[2] !== 8'd250) begin
      errors++;
      $display("FAIL idx1023_capture got %0d want 250", pv[2]);
    end
    sv_seen = 0;
    for (int k = 0; k < 50; k++) begin
      beat(1, 0, 8'd255);
      if (k == 0) begin
        checks++;
        if (sv[2] !== 1'b1) begin
          errors++;
          $display("FAIL idx1023_valid got %0b want 1", sv[2]);
        end
      end else begin
        sv_seen += int'(sv[2]);
      end
    end
    checks++;
    if (sv_seen != 0 || pv[2] !== 8'd250) begin
      errors++;
      $display("FAIL idx1023_nowrap pulses=%0d pv=%0d want 0 and 250", sv_seen, pv[2]);
    end
  endtask

  task automatic test_abort_reset();
    int sv_seen = 0;
    restart();
    for (int col = 0; col < 100; col++) begin
      enable = (col != 30);
      beat(1, col == 0, (col == 63) ? 8'd200 : 8'd0);
      sv_seen += int'(sv[0]);
    end
    checks++;
    if (sv_seen != 0 || mc[0] !== 16'd0) begin
      errors++;
      $display("FAIL abort_midline pulses=%0d mc=%0d want 0 and 0", sv_seen, mc[0]);
    end
    basic_line(200, 0, 0);
    basic_line(200, 1, 0);

    for (int col = 0; col < 64; col++)
      beat(1, col == 0, (col == 63) ? 8'd200 : 8'd0);
    enable = 0;
    beat(1, 0, 8'd0);
    checks++;
    if (sv[0] !== 1'b0 || sd[0] !== 1'b0) begin
      errors++;
      $display("FAIL disable_cancel sv=%0b sd=%0b want 0 0", sv[0], sd[0]);
    end
    enable = 1;
    beat(0, 0, 8'd0);
    basic_line(200, 0, 0);
    basic_line(200, 1, 0);
    for (int col = 0; col < 10; col++)
      beat(1, col == 0, 8'd0);
    beat(1, 1, 8'd0);
    checks++;
    if (mc[0] !== 16'd1 || mp[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_miss mc=%0d mp=%0b want 1 1", mc[0], mp[0]);
    end
    reset = 1;
    beat(1, 0, 8'd0);
    checks++;
    if (sd[0] !== 1'b0 || sv[0] !== 1'b0 || mp[0] !== 1'b0 || pv[0] !== 8'd0 || mc[0] !== 16'd0) begin
      errors++;
      $display("FAIL reset_enabled sd=%0b sv=%0b mp=%0b pv=%0d mc=%0d want all 0",
               sd[0], sv[0], mp[0], pv[0], mc[0]);
    end
    reset = 0;
  endtask

  task automatic test_saturation();
    restart();
    for (int n = 0; n < 20; n++) begin
      beat(1, 1, 8'd0);
      beat(1, 0, 8'd0);
      beat(1, 0, 8'd0);
    end
    beat(1, 1, 8'd0);
    checks++;
    if (mc[3] !== 16'd15) begin
      errors++;
      $display("FAIL sat_width4 got %0d want 15", mc[3]);
    end
    checks++;
    if (mc[0] !== 16'd20 || mc[1] !== 16'd0) begin
      errors++;
      $display("FAIL sat_others idx63=%0d idx0=%0d want 20 and 0", mc[0], mc[1]);
    end
  endtask

  task automatic test_random();
    int rem = 0;
    bit v, ls;
    logic [7:0] d;
    restart();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      reset  = ($urandom_range(0, 999) == 0);
      enable = ($urandom_range(0, 299) != 0);
      v  = ($urandom_range(0, 4) != 0);
      ls = 0;
      if (v) begin
        if (rem == 0) begin
          ls  = 1;
          rem = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1000, 1100))
                                              : int'($urandom_range(1, 90));
        end else begin
          rem--;
        end
      end else begin
        ls = 1'($urandom_range(0, 1));
      end
      case ($urandom_range(0, 2))
        0:       d = 8'($urandom_range(0, 96));
        1:       d = 8'($urandom_range(160, 255));
        default: d = 8'($urandom_range(97, 159));
      endcase
      beat(v, ls, d);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (sd[i] !== m_sd[i]) begin
          errors++;
          $display("FAIL rand_sd dut%0d cyc%0d got %0b want %0b", i, cyc, sd[i], m_sd[i]);
        end
        checks++;
        if (sv[i] !== m_sv[i]) begin
          errors++;
          $display("FAIL rand_sv dut%0d cyc%0d got %0b want %0b", i, cyc, sv[i], m_sv[i]);
        end
        checks++;
        if (mp[i] !== m_mp[i]) begin
          errors++;
          $display("FAIL rand_mp dut%0d cyc%0d got %0b want %0b", i, cyc, mp[i], m_mp[i]);
        end
        checks++;
        if (pv[i] !== 8'(m_pv[i])) begin
          errors++;
          $display("FAIL rand_pv dut%0d cyc%0d got %0d want %0d", i, cyc, pv[i], m_pv[i]);
        end
        checks++;
        if (mc[i] !== 16'(m_mc[i])) begin
          errors++;
          $display("FAIL rand_mc dut%0d cyc%0d got %0d want %0d", i, cyc, mc[i], m_mc[i]);
        end
      end
    end
    reset = 0;
    enable = 1;
  endtask

  initial begin
    reset = 1; enable = 0; data_valid = 0; line_start = 0; data = 8'd0;
    test_reset();
    test_basic_hysteresis();
    test_short_line();
    test_gaps_boundary();
    test_abort_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_sample_extractor.md
Name: pixel_sample_extractor

Overview:
- Upstream stage of the frequency analyzer chain. Extracts one pixel per video line at a fixed column index from an 8-bit pixel stream.
- Converts that pixel to a 1-bit level using hysteresis thresholds, then filters the level across lines.
- Drives sample_data / sample_valid into a frequency_analyzer instance. One instance is used per monitored pixel.

Parameters:
- DATA_WIDTH, 8: pixel data width.
- INDEX_WIDTH, 10: width of the column counter.
- PIXEL_INDEX, 63: column captured each line (0-based). Must be < 2^INDEX_WIDTH.
- THRESHOLD_HIGH, 160: captured value >= this gives candidate level 1.
- THRESHOLD_LOW, 96: captured value <= this gives candidate level 0. Must be < THRESHOLD_HIGH.
- FILTER_LENGTH, 2: consecutive disagreeing lines needed to flip sample_data. Range 1..15.
- MISSED_WIDTH, 16: width of the missed-line counter.

Ports:
- clock, input, 1: single clock for the whole block.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: run control. Low = synchronous clear to idle.
- data, input, DATA_WIDTH: pixel value.
- data_valid, input, 1: data carries a pixel this cycle.
- line_start, input, 1: qualified by data_valid; marks column 0 of a new line.
- sample_data, output, 1: filtered pixel level.
- sample_valid, output, 1: 1-cycle pulse per captured line.
- pixel_value, output, DATA_WIDTH: last captured raw pixel.
- missed_pulse, output, 1: 1-cycle pulse when a line ends before PIXEL_INDEX is reached.
- missed_count, output, MISSED_WIDTH: saturating count of missed lines.

Behaviour:
- Reset (reset=1) and enable=0 act identically and are synchronous:
  - State goes to IDLE.
  - Column counter, filter counter, sample_data, sample_valid, pixel_value, missed_pulse and missed_count all go to 0.
- States:
  - IDLE: on enable=1, go to WAIT_LINE next cycle.
  - WAIT_LINE: discard beats until a beat with data_valid=1 and line_start=1.
    - That beat is column 0. The column counter is set to 1 and the state goes to COUNT.
    - If PIXEL_INDEX=0, that beat is captured and the state goes to DONE.
  - COUNT: each data_valid beat with line_start=0 is column = counter.
    - Counter increments, saturating at 2^INDEX_WIDTH-1 with no wrap.
    - When column == PIXEL_INDEX, capture data and go to DONE.
  - DONE: ignore beats until the next line_start beat, then handle it as in WAIT_LINE.
- line_start beat while in COUNT (line shorter than PIXEL_INDEX+1):
  - missed_pulse=1 on the next cycle. missed_count increments, saturating at all-ones.
  - The same beat starts the new line as column 0 (captured if PIXEL_INDEX=0).
- line_start with data_valid=0: ignored in all states.
- data_valid=0 beats: no counting and no state change.
- Capture pipeline, with the capture beat at cycle N:
  - N+1: pixel_value <= captured data. Candidate level is computed:
    - 1 if value >= THRESHOLD_HIGH;
    - 0 if value <= THRESHOLD_LOW;
    - otherwise the current sample_data (hysteresis band).
  - N+2: filter update, sample_valid=1 for exactly one cycle.
- Filter:
  - candidate == sample_data: filter counter <= 0.
  - Otherwise the counter increments. When it reaches FILTER_LENGTH, sample_data flips and the counter <= 0.
  - FILTER_LENGTH=1 means sample_data follows the candidate with no delay.
- Pipeline disable: enable falling while the pipeline is in flight cancels pending sample_valid and missed_pulse.
- Output timing: all outputs are registered, with no combinational path from inputs.
- Throughput: one pixel per clock. At most one capture per line.

Test Plan:
- Basic capture: reset, enable=1, PIXEL_INDEX=63. Stream a 100-pixel line with line_start on pixel 0 and value 200 at column 63, 0 elsewhere.
  -> pixel_value=200 at capture+1; sample_valid pulse at capture+2.
  -> sample_data stays 0 after the first line (FILTER_LENGTH=2); becomes 1 at the second such line's sample_valid.
- Hysteresis: with sample_data=1, send lines whose column-63 values are 120, 120, 120 (in band).
  -> sample_data stays 1.
  -> Then two lines at 90 -> sample_data=0 on the second sample_valid.
- Short line: 40-pixel line followed by a line_start.
  -> missed_pulse on the cycle after the line_start; missed_count=1; no sample_valid.
  -> The following full line captures normally.
- Gaps and boundary index: data_valid toggling 1/0 every cycle with PIXEL_INDEX=0 -> line_start pixel value is captured. With PIXEL_INDEX=1023 and a 1024-pixel line -> last pixel captured, counter does not wrap.
- Abort and reset: enable=0 at column 30, then enable=1 mid-line.
  -> No capture until the next line_start; missed_count=0.
  -> reset=1 with enable held high clears all outputs to 0 on the next edge.
- Saturation: MISSED_WIDTH=4 with 20 short lines -> missed_count holds at 15.
